// File: rtl/addsub_pkg.sv
// Shared constants and saturation limits for the multi-lane signed adder/subtractor.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Limits are returned zero-extended to 32 bits; callers take the low len bits.
  function automatic logic [31:0] max_pos(input int unsigned len);
    return (32'd1 << (len - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] min_neg(input int unsigned len);
    return 32'd1 << (len - 1);
  endfunction

endpackage

// File: rtl/addsub_lane.sv
// One combinational lane: signed add or subtract with overflow detect and optional clamp.
module addsub_lane
  import addsub_pkg::*;
#(
  parameter int unsigned LEN = 16
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic           op,
  input  logic           sat,
  output logic [LEN-1:0] r,
  output logic           ovf
);

  localparam logic [LEN-1:0] POS_LIM = LEN'(max_pos(LEN));
  localparam logic [LEN-1:0] NEG_LIM = LEN'(min_neg(LEN));

  logic [LEN-1:0] b_eff;
  logic [LEN-1:0] sum;
  logic           sign_a;
  logic           sign_b;
  logic           sign_r;

  always_comb begin
    b_eff  = (op == OP_SUB) ? ~b : b;
    sum    = a + b_eff + LEN'(op == OP_SUB);
    sign_a = a[LEN-1];
    sign_b = b[LEN-1];
    sign_r = sum[LEN-1];
    if (op == OP_SUB) begin
      ovf = (sign_a != sign_b) && (sign_r != sign_a);
    end else begin
      ovf = (sign_a == sign_b) && (sign_r != sign_a);
    end
    r = sum;
    // Clamp direction follows the sign of A, which is the true sign of the result.
    if (sat && ovf) begin
      r = sign_a ? NEG_LIM : POS_LIM;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// LANES-wide pipelined signed add/sub with valid/ready flow control, per-lane overflow,
// sticky overflow status and a saturating overflow-event counter.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned LEN    = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*LEN-1:0]  in1,
  input  logic [LANES*LEN-1:0]  in2,
  input  logic                  op,
  input  logic                  sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LEN-1:0]  out,
  output logic [LANES-1:0]      ovf,
  output logic [LANES-1:0]      ovf_sticky,
  output logic [CNT_W-1:0]      ovf_count,
  input  logic                  ovf_clear
);

  localparam int unsigned W = LANES * LEN;

  logic [W-1:0]     lane_r;
  logic [LANES-1:0] lane_ovf;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    addsub_lane #(
      .LEN(LEN)
    ) u_lane (
      .a  (in1[l*LEN +: LEN]),
      .b  (in2[l*LEN +: LEN]),
      .op (op),
      .sat(sat),
      .r  (lane_r[l*LEN +: LEN]),
      .ovf(lane_ovf[l])
    );
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] v_in;
  logic [W-1:0]      data   [STAGES];
  logic [W-1:0]      d_in   [STAGES];
  logic [LANES-1:0]  ovf_q  [STAGES];
  logic [LANES-1:0]  o_in   [STAGES];
  logic              xfer;
  logic              any_ovf;

  // Load enables ripple back from out_ready so a stage refills in the cycle it drains.
  always_comb begin
    logic adv;
    int unsigned i;
    adv  = out_ready;
    load = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      i       = STAGES - 1 - k;
      load[i] = !v[i] || adv;
      adv     = load[i];
    end
  end

  always_comb begin
    v_in[0] = in_valid;
    d_in[0] = lane_r;
    o_in[0] = lane_ovf;
    for (int unsigned i = 1; i < STAGES; i++) begin
      v_in[i] = v[i-1];
      d_in[i] = data[i-1];
      o_in[i] = ovf_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data[i]  <= '0;
        ovf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          v[i] <= v_in[i];
          if (v_in[i]) begin
            data[i]  <= d_in[i];
            ovf_q[i] <= o_in[i];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[STAGES-1];
  assign out       = data[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];
  assign xfer      = out_valid && out_ready;
  assign any_ovf   = |ovf_q[STAGES-1];

  // A clear coincident with an overflowing transfer keeps that transfer's contribution.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= '0;
      ovf_count  <= '0;
    end else if (ovf_clear) begin
      ovf_sticky <= xfer ? ovf : '0;
      ovf_count  <= (xfer && any_ovf) ? CNT_W'(1) : '0;
    end else if (xfer) begin
      ovf_sticky <= ovf_sticky | ovf;
      if (any_ovf && (ovf_count != '1)) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: integer reference model, decoupled driver and monitor.
module tb_addsub_pipe;

  localparam int LEN    = 9;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;
  localparam int W      = LANES * LEN;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in1, in2;
  logic             op, sat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [LANES-1:0] ovf;
  logic [LANES-1:0] ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic             ovf_clear;

  addsub_pipe #(
    .LEN   (LEN),
    .LANES (LANES),
    .STAGES(STAGES),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_count (ovf_count),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     res;
    logic [LANES-1:0] ovf;
    int               acc_cyc;
    int               acc_stalls;
  } exp_t;

  exp_t             sbq[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               stalls = 0;
  logic [LANES-1:0] m_sticky = '0;
  int               m_count = 0;
  logic             rdy_level = 1'b1;
  logic             rand_mode = 1'b0;
  logic             prev_stall = 1'b0;
  logic [W-1:0]     held_out;
  logic [LANES-1:0] held_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    logic [W-1:0]  v;
    logic [31:0]   t;
    int            xs[LANES];
    xs = '{x0, x1, x2, x3};
    v  = '0;
    for (int l = 0; l < LANES; l++) begin
      t = xs[l];
      v[l*LEN +: LEN] = t[LEN-1:0];
    end
    return v;
  endfunction

  // Reference: exact integer result, then range test and clamp/wrap.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic o, input logic s);
    exp_t                   e;
    logic signed [LEN-1:0]  sa, sb;
    int                     ra, rb, res;
    logic [31:0]            t;
    int                     maxv = (1 << (LEN - 1)) - 1;
    int                     minv = -(1 << (LEN - 1));
    e.res = '0;
    e.ovf = '0;
    e.acc_cyc = 0;
    e.acc_stalls = 0;
    for (int l = 0; l < LANES; l++) begin
      sa  = a[l*LEN +: LEN];
      sb  = b[l*LEN +: LEN];
      ra  = sa;
      rb  = sb;
      res = o ? (ra - rb) : (ra + rb);
      if (res > maxv || res < minv) begin
        e.ovf[l] = 1'b1;
        if (s) res = (res > maxv) ? maxv : minv;
      end
      t = res;
      e.res[l*LEN +: LEN] = t[LEN-1:0];
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rand_mode ? ($urandom % 4 != 0) : rdy_level;
  end

  // Monitor: records accepted inputs, checks outputs and status registers.
  always @(negedge clk) begin
    exp_t             e;
    logic             x;
    logic [LANES-1:0] x_ovf;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("ovf_sticky", ovf_sticky, m_sticky);
      chk("ovf_count", ovf_count, m_count);
      if (prev_stall && out_valid) begin
        chk("stall_out_stable", out, held_out);
        chk("stall_ovf_stable", ovf, held_ovf);
      end
      if (in_valid && in_ready) begin
        e = model(in1, in2, op, sat);
        e.acc_cyc = cyc;
        e.acc_stalls = stalls;
        sbq.push_back(e);
      end
      x = 1'b0;
      x_ovf = '0;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else if (out_ready) begin
          e = sbq.pop_front();
          chk("out", out, e.res);
          chk("ovf", ovf, e.ovf);
          if (e.acc_stalls == stalls) chk("latency", cyc - e.acc_cyc, STAGES);
          x = 1'b1;
          x_ovf = e.ovf;
        end
      end
      if (ovf_clear) begin
        m_sticky = x ? x_ovf : '0;
        m_count  = (x && |x_ovf) ? 1 : 0;
      end else if (x) begin
        m_sticky = m_sticky | x_ovf;
        if (|x_ovf && m_count < CNT_MAX) m_count++;
      end
      if (!out_ready) stalls++;
      prev_stall = out_valid && !out_ready;
      held_out = out;
      held_ovf = ovf;
    end
  end

  // Called aligned at posedge+1; returns aligned at posedge+1 after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o, input logic s);
    int n = 0;
    in1 = a;
    in2 = b;
    op = o;
    sat = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] ra, rb;
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    send(ra[W-1:0], rb[W-1:0], 1'($urandom % 2), 1'($urandom % 2));
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    ovf_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    op = 1'b0;
    sat = 1'b0;
    ovf_clear = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, '0);
    chk("rst_ovf", ovf, '0);
    chk("rst_sticky", ovf_sticky, '0);
    chk("rst_count", ovf_count, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-lane cases in lane 0
    send(pack4(100, 0, 0, 0), pack4(88, 0, 0, 0), 1'b0, 1'b0);
    send(pack4(200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b0, 1'b0);
    send(pack4(200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b0, 1'b1);
    drain();
    chk("dir_count_2", ovf_count, 2);
    chk("dir_sticky", ovf_sticky, 4'b0001);
    send(pack4(100, 0, 0, 0), pack4(-231, 0, 0, 0), 1'b1, 1'b1);
    send(pack4(-200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b1, 1'b1);
    send(pack4(5, 0, 0, 0), pack4(7, 0, 0, 0), 1'b1, 1'b0);
    drain();

    // Mixed lanes, only lane 1 overflows
    clear_pulse();
    send(pack4(10, 200, -5, -100), pack4(20, 100, -7, 50), 1'b0, 1'b0);
    drain();
    chk("mixed_count", ovf_count, 1);
    chk("mixed_sticky", ovf_sticky, 4'b0010);

    // Clear coincident with an overflowing transfer on lane 2
    rdy_level = 1'b0;
    send(pack4(0, 0, 250, 0), pack4(0, 0, 10, 0), 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wait_valid_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rdy_level = 1'b1;
    ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    ovf_clear = 1'b0;
    drain();
    chk("clr_set_sticky", ovf_sticky, 4'b0100);
    chk("clr_set_count", ovf_count, 1);

    // Back-to-back stream with a 5-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        rdy_level = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready_low", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        rdy_level = 1'b1;
      end
    join
    drain();

    // Counter saturation
    clear_pulse();
    for (int i = 0; i < CNT_MAX + 5; i++)
      send(pack4(200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b0, 1'b0);
    drain();
    chk("count_saturated", ovf_count, CNT_MAX);

    // Random traffic with random back-pressure and occasional clears
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ovf_clear = ($urandom % 16 == 0);
      send_rand();
    end
    ovf_clear = 1'b0;
    rand_mode = 1'b0;
    drain();

    // Asynchronous reset with two transactions in flight
    send(pack4(200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b0, 1'b0);
    drain();
    rdy_level = 1'b0;
    send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b0);
    send(pack4(200, 0, 0, 0), pack4(100, 0, 0, 0), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out", out, '0);
    chk("midrst_ovf", ovf, '0);
    chk("midrst_sticky", ovf_sticky, '0);
    chk("midrst_count", ovf_count, '0);
    sbq.delete();
    m_sticky = '0;
    m_count = 0;
    rdy_level = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    send(pack4(-3, 4, 100, -256), pack4(2, -9, 100, 1), 1'b0, 1'b1);
    drain();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, multi-lane, pipelined signed adder/subtractor for the ALU datapath. It generalises the combinational `addSub` unit to LANES independent lanes with per-transaction add/sub mode, optional saturation, valid/ready flow control, per-lane overflow flags, sticky overflow status and a saturating overflow-event counter. It sits between the PE operand buffers and the ALU result mux.

## Interface
- LEN, 16, lane width in bits; two's-complement signed.
- LANES, 4, number of independent lanes.
- STAGES, 2, pipeline register stages (legal 1..4); equals latency.
- CNT_W, 16, overflow-event counter width.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  stage 0 can accept this cycle.
- in1  in  LANES*LEN  operand A; lane l at [l*LEN +: LEN].
- in2  in  LANES*LEN  operand B, same packing.
- op  in  1  0 = add (A+B), 1 = sub (A-B); applies to all lanes.
- sat  in  1  1 = clamp on overflow, 0 = wrap.
- out_valid  out  1  result present at last stage.
- out_ready  in  1  consumer accepts result.
- out  out  LANES*LEN  per-lane result.
- ovf  out  LANES  per-lane overflow flag of the presented result (set even when saturated).
- ovf_sticky  out  LANES  per-lane sticky overflow.
- ovf_count  out  CNT_W  count of output transfers with any lane overflowing; saturates at all-ones.
- ovf_clear  in  1  synchronous clear of ovf_sticky and ovf_count.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Per lane, computed combinationally before stage 0 register: r = A + B (op=0) or A + ~B + 1 (op=1), LEN-bit result.
- Overflow: add: sign(A)==sign(B) && sign(r)!=sign(A); sub: sign(A)!=sign(B) && sign(r)!=sign(A).
- Saturation (sat=1 && overflow): r = 2^(LEN-1)-1 if sign(A)=0, else -2^(LEN-1). sat=0: wrapped r.
- Pipeline: stage i holds valid bit v[i], LANES*LEN result, LANES ovf bits. Stage i loads from stage i-1 (stage 0 from inputs) when !v[i] || advance[i+1]; last stage advances on out_ready. in_ready = !v[0] || advance[1] (advance of last = out_ready). Bubbles collapse; full throughput of one transaction per cycle with out_ready held high.
- Data/ovf registers load only when their stage loads with valid data; hold otherwise (stable while out_valid && !out_ready).
- Sticky/counter update only on output transfer: ovf_sticky[l] |= ovf[l]; ovf_count += 1 if |ovf, saturating.
- ovf_clear same cycle as a set event: set wins for sticky (bit ends 1); counter ends at 1 if the transfer overflowed, else 0.

## Timing
- Latency: a transaction accepted at edge N is on out at edge N+STAGES if no stall.
- in_ready combinational from out_ready and stage valids; no combinational path from in1/in2 to out.
- Reset (any time, asynchronous): all v[i]=0, out=0, ovf=0, ovf_sticky=0, ovf_count=0. in-flight transactions are discarded; in_ready=1 after reset.
- Back-pressure: with out_ready=0 the pipeline fills STAGES deep, then in_ready=0; no transaction lost or duplicated.
- ovf_count at all-ones stays all-ones on further overflow events.

## Structure
- Package addsub_pkg: OP_ADD=1'b0, OP_SUB=1'b1 constants; functions for max_pos(LEN)/min_neg(LEN).
- Sub-module addsub_lane (combinational: A, B, op, sat -> r, ovf), instanced LANES times; addsub_pipe owns pipeline, handshake, sticky and counter.

## Test plan
- LEN=9, LANES=1, STAGES=2: add 100+88, sat=0 -> out=188, ovf=0, out_valid exactly 2 cycles after acceptance.
- Add 200+100: sat=0 -> out=-212 (9'h12C), ovf=1; sat=1 -> out=255, ovf=1; ovf_sticky=1, ovf_count=2.
- Sub 100-(-231), sat=1 -> 255, ovf=1; sub -200-100, sat=1 -> -256, ovf=1; sub 5-7 -> -2, ovf=0.
- Stream 8 back-to-back transactions, out_ready low for cycles 3-6: in_ready drops after 2 buffered, all 8 results emerge in order, none repeated, data stable during stall.
- LANES=4 mixed lanes (one overflowing): only that ovf bit set; ovf_count increments by 1; ovf_clear coincident with an overflowing transfer -> sticky bit stays 1, count=1.
- Assert reset_n low mid-stream with 2 in flight: out_valid, out, ovf, sticky, count go 0 immediately; no stale output after release.
